// File: rtl/rename_regfile_pkg.sv
// Shared constants for the rename register file and the reorder buffer.
package rename_regfile_pkg;

    // Default geometry of the rename register file.
    localparam int RRF_NUM_DEF  = 64;
    localparam int RRF_SEL_DEF  = 6;
    localparam int DATA_LEN_DEF = 32;

    // Number of result write ports {branch, ldst, mul, alu2, alu1}.
    localparam int WR_PORTS = 5;

    // Number of operand read ports.
    localparam int RD_PORTS = 4;

endpackage

// File: rtl/rrf_freelist_ctr.sv
// Dispatch pointer and free-entry counter of the rename register file.
//
// Handshake:
//   - req1/req2 form the request side, and allocatable is the grant side.
//   - Entries are handed out only in a cycle where the requests fit, and neither stall nor prmiss is high.
//   - alloc_num reports how many entries were taken in that cycle.
module rrf_freelist_ctr
    import rename_regfile_pkg::*;
#(
    parameter int RRF_NUM = RRF_NUM_DEF,
    parameter int RRF_SEL = RRF_SEL_DEF
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               req1,
    input  logic               req2,
    input  logic               stall,
    input  logic               prmiss,
    input  logic [1:0]         comnum,
    input  logic [RRF_SEL-1:0] comptr,
    output logic               allocatable,
    output logic [1:0]         alloc_num,
    output logic [RRF_SEL-1:0] dispatchptr,
    output logic [RRF_SEL-1:0] dp2_addr,
    output logic [RRF_SEL:0]   rrf_freenum
);

    localparam logic [RRF_SEL:0] FREE_FULL = (RRF_SEL+1)'(RRF_NUM);

    logic [1:0] req_num;

    // Grant decision: requests must fit in the free entries; stall/prmiss suppress allocation.
    always_comb begin
        req_num     = {1'b0, req1} + {1'b0, req2};
        allocatable = ((RRF_SEL+1)'(req_num) <= rrf_freenum);
        alloc_num   = (allocatable && !stall && !prmiss) ? req_num : 2'd0;
        dp2_addr    = dispatchptr + RRF_SEL'(req1);
    end

    // Pointer/count update: mispredict restores the empty state at the commit pointer.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            dispatchptr <= '0;
            rrf_freenum <= FREE_FULL;
        end else if (prmiss) begin
            dispatchptr <= comptr;
            rrf_freenum <= FREE_FULL;
        end else begin
            dispatchptr <= dispatchptr + RRF_SEL'(alloc_num);
            rrf_freenum <= rrf_freenum - (RRF_SEL+1)'(alloc_num) + (RRF_SEL+1)'(comnum);
        end
    end

endmodule

// File: rtl/rename_regfile.sv
// Rename register file: result storage and valid bits, plus the free-list counter.
// Reads are combinational with no write bypass; a write becomes visible the cycle after.
module rename_regfile
    import rename_regfile_pkg::*;
#(
    parameter int RRF_NUM  = RRF_NUM_DEF,
    parameter int RRF_SEL  = RRF_SEL_DEF,
    parameter int DATA_LEN = DATA_LEN_DEF
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           req1,
    input  logic                           req2,
    input  logic                           stall,
    input  logic                           prmiss,
    input  logic [1:0]                     comnum,
    input  logic [RRF_SEL-1:0]             comptr,
    output logic                           allocatable,
    output logic [RRF_SEL-1:0]             dispatchptr,
    output logic [RRF_SEL-1:0]             dp2_addr,
    output logic [RRF_SEL:0]               rrf_freenum,
    input  logic [WR_PORTS-1:0]            wen,
    input  logic [WR_PORTS*RRF_SEL-1:0]    waddr,
    input  logic [WR_PORTS*DATA_LEN-1:0]   wdata,
    input  logic [RD_PORTS*RRF_SEL-1:0]    raddr,
    output logic [RD_PORTS*DATA_LEN-1:0]   rdata,
    output logic [RD_PORTS-1:0]            rvalid,
    output logic [DATA_LEN-1:0]            comdata1,
    output logic [DATA_LEN-1:0]            comdata2
);

    logic [1:0]          alloc_num;
    logic [RRF_NUM-1:0]  valid;
    logic [RRF_NUM-1:0]  valid_nxt;
    logic [DATA_LEN-1:0] mem [RRF_NUM];
    logic [RRF_SEL-1:0]  comptr_p1;

    rrf_freelist_ctr #(
        .RRF_NUM (RRF_NUM),
        .RRF_SEL (RRF_SEL)
    ) u_freelist (
        .clk         (clk),
        .reset       (reset),
        .req1        (req1),
        .req2        (req2),
        .stall       (stall),
        .prmiss      (prmiss),
        .comnum      (comnum),
        .comptr      (comptr),
        .allocatable (allocatable),
        .alloc_num   (alloc_num),
        .dispatchptr (dispatchptr),
        .dp2_addr    (dp2_addr),
        .rrf_freenum (rrf_freenum)
    );

    // Valid next-state: writes set, allocation clears; the clear is applied last so it wins.
    always_comb begin
        valid_nxt = valid;
        for (int i = 0; i < WR_PORTS; i++) begin
            if (wen[i]) begin
                valid_nxt[waddr[i*RRF_SEL +: RRF_SEL]] = 1'b1;
            end
        end
        if (alloc_num != 2'd0) begin
            valid_nxt[dispatchptr] = 1'b0;
        end
        if (alloc_num == 2'd2) begin
            valid_nxt[dp2_addr] = 1'b0;
        end
    end

    // Valid bit register; mispredict leaves it alone, re-allocation clears entries.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            valid <= '0;
        end else begin
            valid <= valid_nxt;
        end
    end

    // Result storage; no reset, since an entry's data is meaningless until its valid bit is set.
    always_ff @(posedge clk) begin
        for (int i = 0; i < WR_PORTS; i++) begin
            if (wen[i]) begin
                mem[waddr[i*RRF_SEL +: RRF_SEL]] <= wdata[i*DATA_LEN +: DATA_LEN];
            end
        end
    end

    // Operand and commit reads straight from stored state.
    always_comb begin
        comptr_p1 = comptr + RRF_SEL'(1);
        for (int i = 0; i < RD_PORTS; i++) begin
            rdata[i*DATA_LEN +: DATA_LEN] = mem[raddr[i*RRF_SEL +: RRF_SEL]];
            rvalid[i]                     = valid[raddr[i*RRF_SEL +: RRF_SEL]];
        end
        comdata1 = mem[comptr];
        comdata2 = mem[comptr_p1];
    end

endmodule

// File: tb/tb_rename_regfile.sv
// Directed bench for rename_regfile: allocation, wrap, retirement, writes/reads, mispredict, async reset.
module tb_rename_regfile;

    localparam int SEL = 6;
    localparam int DL  = 32;

    logic            clk = 1'b0;
    logic            reset;
    logic            req1, req2, stall, prmiss;
    logic [1:0]      comnum;
    logic [SEL-1:0]  comptr;
    logic            allocatable;
    logic [SEL-1:0]  dispatchptr, dp2_addr;
    logic [SEL:0]    rrf_freenum;
    logic [4:0]      wen;
    logic [5*SEL-1:0] waddr;
    logic [5*DL-1:0] wdata;
    logic [4*SEL-1:0] raddr;
    logic [4*DL-1:0] rdata;
    logic [3:0]      rvalid;
    logic [DL-1:0]   comdata1, comdata2;

    int tests_run = 0;
    int tests_failed = 0;

    rename_regfile dut (
        .clk         (clk),
        .reset       (reset),
        .req1        (req1),
        .req2        (req2),
        .stall       (stall),
        .prmiss      (prmiss),
        .comnum      (comnum),
        .comptr      (comptr),
        .allocatable (allocatable),
        .dispatchptr (dispatchptr),
        .dp2_addr    (dp2_addr),
        .rrf_freenum (rrf_freenum),
        .wen         (wen),
        .waddr       (waddr),
        .wdata       (wdata),
        .raddr       (raddr),
        .rdata       (rdata),
        .rvalid      (rvalid),
        .comdata1    (comdata1),
        .comdata2    (comdata2)
    );

    // Clock generation.
    always #5 clk = ~clk;

    // Two write ports must never target the same entry in one cycle.
    always @(posedge clk) begin
        for (int i = 0; i < 5; i++) begin
            for (int j = i + 1; j < 5; j++) begin
                assert (!(wen[i] && wen[j] && waddr[i*SEL +: SEL] == waddr[j*SEL +: SEL]))
                    else $error("write port conflict on ports %0d and %0d", i, j);
            end
        end
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_write(input int port, input logic [SEL-1:0] addr, input logic [DL-1:0] data);
        wen[port]               = 1'b1;
        waddr[port*SEL +: SEL]  = addr;
        wdata[port*DL +: DL]    = data;
    endtask

    initial begin
        reset = 1'b0; req1 = 0; req2 = 0; stall = 0; prmiss = 0;
        comnum = 0; comptr = 0; wen = 0; waddr = 0; wdata = 0; raddr = 0;

        // Reset state
        repeat (2) step();
        check("rst_dp", dispatchptr, 0);
        check("rst_free", rrf_freenum, 64);
        check("rst_allocatable", allocatable, 1);
        check("rst_rvalid", rvalid, 0);
        reset = 1'b1;

        // Test 1: 32 double allocations drain the free list
        req1 = 1; req2 = 1;
        for (int k = 0; k < 32; k++) begin
            #1;
            check("t1_dp", dispatchptr, 2 * k);
            check("t1_free", rrf_freenum, 64 - 2 * k);
            check("t1_alloc", allocatable, 1);
            step();
        end
        #1;
        check("t1_dp_wrap", dispatchptr, 0);
        check("t1_free_empty", rrf_freenum, 0);
        check("t1_alloc_empty", allocatable, 0);

        // Retire 2 with nothing allocated, from an empty free list
        req1 = 0; req2 = 0; comnum = 2;
        step();
        check("ret_free", rrf_freenum, 2);
        comnum = 0; req1 = 1;
        step();
        check("single_dp", dispatchptr, 1);
        check("single_free", rrf_freenum, 1);

        // Test 2: two requests, one free entry
        req2 = 1;
        #1;
        check("t2_alloc0", allocatable, 0);
        step();
        check("t2_hold_dp", dispatchptr, 1);
        check("t2_hold_free", rrf_freenum, 1);
        req2 = 0;
        #1;
        check("t2_alloc1", allocatable, 1);
        step();
        check("t2_dp", dispatchptr, 2);
        check("t2_free", rrf_freenum, 0);

        // Mispredict to 63 to set up the wrap
        req1 = 0; prmiss = 1; comptr = 63;
        step();
        prmiss = 0;
        check("pm63_dp", dispatchptr, 63);
        check("pm63_free", rrf_freenum, 64);

        // Test 3: allocation across the wrap with one retirement
        req1 = 1; req2 = 1; comnum = 1;
        #1;
        check("t3_dp2", dp2_addr, 0);
        step();
        req1 = 0; req2 = 0; comnum = 0;
        check("t3_dp", dispatchptr, 1);
        check("t3_free", rrf_freenum, 63);

        // Test 4: write entry 5, read it back the cycle after
        set_write(2, 5, 32'hDEADBEEF);
        raddr[0*SEL +: SEL] = 5;
        comptr = 4;
        #1;
        check("t4_rvalid_same", rvalid[0], 0);
        step();
        wen = 0;
        check("t4_rvalid", rvalid[0], 1);
        check("t4_rdata", rdata[0 +: DL], 32'hDEADBEEF);
        check("t4_comdata2", comdata2, 32'hDEADBEEF);

        // Commit read wrap: entry 0 seen through comptr=63
        set_write(0, 0, 32'h12345678);
        step();
        wen = 0;
        comptr = 63;
        #1;
        check("wrap_comdata2", comdata2, 32'h12345678);
        comptr = 5;
        #1;
        check("comdata1", comdata1, 32'hDEADBEEF);

        // Allocation clear beats a write to the same entry; other write lands
        req1 = 1;
        set_write(1, 1, 32'h0000AAAA);
        set_write(3, 2, 32'h0000BBBB);
        raddr[1*SEL +: SEL] = 1;
        raddr[2*SEL +: SEL] = 2;
        step();
        req1 = 0; wen = 0;
        check("clr_wins_rvalid", rvalid[1], 0);
        check("other_rvalid", rvalid[2], 1);
        check("other_rdata", rdata[2*DL +: DL], 32'h0000BBBB);
        check("clr_dp", dispatchptr, 2);

        // Test 5: mispredict overrides requests and retirement
        req1 = 1; req2 = 1; comnum = 2; prmiss = 1; comptr = 17;
        step();
        prmiss = 0; comnum = 0; req1 = 0; req2 = 0;
        check("t5_dp", dispatchptr, 17);
        check("t5_free", rrf_freenum, 64);
        check("t5_valid_kept", rvalid[0], 1);

        // Stall blocks allocation
        req1 = 1; req2 = 1; stall = 1;
        step();
        stall = 0;
        check("stall_dp", dispatchptr, 17);
        check("stall_free", rrf_freenum, 64);

        // Test 6: async reset mid-burst
        repeat (3) step();
        check("t6_pre_dp", dispatchptr, 23);
        check("t6_pre_rvalid", rvalid[0], 1);
        reset = 1'b0;
        #1;
        check("t6_dp", dispatchptr, 0);
        check("t6_free", rrf_freenum, 64);
        check("t6_alloc", allocatable, 1);
        check("t6_rvalid", rvalid, 0);
        #2;
        reset = 1'b1;
        step();
        check("t6_resume_dp", dispatchptr, 2);
        check("t6_resume_free", rrf_freenum, 62);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
